// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : shared types, rounding modes and saturation helper
// Rev 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ROUND_FLOOR   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                     input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_accumulator_if.sv
// ============================================================================
// shift_accumulator_if : request/result valid-ready bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface shift_accumulator_if #(
  parameter int WIDTH     = 21,
  parameter int SHAMT_W   = 4,
  parameter int MAX_TERMS = 4
);
  localparam int NW = $clog2(MAX_TERMS + 1);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [WIDTH-1:0]      in_data;
  logic [NW-1:0]                in_nterms;
  logic [MAX_TERMS*SHAMT_W-1:0] in_shamt;
  logic [MAX_TERMS-1:0]         in_dir;
  logic [MAX_TERMS-1:0]         in_neg;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [WIDTH-1:0]      out_data;
  logic                         out_sat;

  modport master (
    output in_valid, in_data, in_nterms, in_shamt, in_dir, in_neg, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_nterms, in_shamt, in_dir, in_neg, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

`default_nettype wire

// File: rtl/shift_term.sv
// ============================================================================
// shift_term : combinational single-term shifter (saturating left, arith right)
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_term
  import shift_pkg::*;
#(
  parameter int WIDTH   = 21,
  parameter int SHAMT_W = 4,
  parameter int ROUND   = ROUND_FLOOR
) (
  input  logic signed [WIDTH-1:0] i_x,
  input  logic [SHAMT_W-1:0]      i_s,
  input  logic                    i_dir,
  output logic signed [WIDTH-1:0] o_term,
  output logic                    o_sat
);

  localparam int EXTW = WIDTH + 2**SHAMT_W;

  logic signed [EXTW-1:0]  w_shl;
  logic signed [WIDTH-1:0] w_shr;
  logic signed [WIDTH-1:0] w_satval;
  logic                    w_ovf;
  logic                    w_rbit;

  always_comb begin
    w_shl    = EXTW'(i_x) <<< i_s;
    // Everything from the new sign bit upward must replicate the original sign.
    w_ovf    = (w_shl[EXTW-1:WIDTH-1] != {(EXTW-WIDTH+1){i_x[WIDTH-1]}});
    w_satval = i_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    // Bit s-1 of x; shifting past the top yields the sign bit automatically.
    w_rbit   = (ROUND == ROUND_HALF_UP) && (i_s != '0) &&
               1'(i_x >>> (i_s - SHAMT_W'(1)));
    w_shr    = (i_x >>> i_s) + $signed({{(WIDTH-1){1'b0}}, w_rbit});
    o_sat    = !i_dir && w_ovf;
    o_term   = i_dir ? w_shr : (w_ovf ? w_satval : w_shl[WIDTH-1:0]);
  end

endmodule

`default_nettype wire

// File: rtl/shift_accumulator.sv
// ============================================================================
// shift_accumulator : multi-cycle signed shift-and-accumulate, one term/clock
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_accumulator
  import shift_pkg::*;
#(
  parameter int WIDTH     = 21,
  parameter int SHAMT_W   = 4,
  parameter int MAX_TERMS = 4,
  parameter int ROUND     = ROUND_FLOOR
) (
  input  logic               clk,
  input  logic               rst,
  shift_accumulator_if.slave bus
);

  localparam int NW   = $clog2(MAX_TERMS + 1);
  localparam int IDXW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
  localparam int ACCW = WIDTH + $clog2(MAX_TERMS) + 1;

  state_t                       r_state;
  state_t                       w_next;
  logic signed [WIDTH-1:0]      r_x;
  logic [MAX_TERMS*SHAMT_W-1:0] r_shamt;
  logic [MAX_TERMS-1:0]         r_dir;
  logic [MAX_TERMS-1:0]         r_neg;
  logic [NW-1:0]                r_n;
  logic [NW-1:0]                r_idx;
  logic signed [ACCW-1:0]       r_acc;
  logic                         r_sat;
  logic signed [WIDTH-1:0]      r_out_data;
  logic                         r_out_sat;

  logic [NW-1:0]                w_n_clamp;
  logic [IDXW-1:0]              w_sel;
  logic [SHAMT_W-1:0]           w_shamt;
  logic signed [WIDTH-1:0]      w_term;
  logic                         w_term_sat;
  logic signed [ACCW-1:0]       w_term_ext;
  logic signed [ACCW-1:0]       w_addend;
  logic signed [ACCW-1:0]       w_acc_next;
  logic signed [63:0]           w_acc_ext;
  logic signed [63:0]           w_acc_clamp;
  logic                         w_fsat;
  logic                         w_last;

  assign w_n_clamp = (bus.in_nterms > NW'(MAX_TERMS)) ? NW'(MAX_TERMS) : bus.in_nterms;
  assign w_sel     = r_idx[IDXW-1:0];
  assign w_shamt   = r_shamt[w_sel*SHAMT_W +: SHAMT_W];

  shift_term #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .ROUND   (ROUND)
  ) u_term (
    .i_x    (r_x),
    .i_s    (w_shamt),
    .i_dir  (r_dir[w_sel]),
    .o_term (w_term),
    .o_sat  (w_term_sat)
  );

  // Negate after widening so that -(-2^(WIDTH-1)) stays exact.
  assign w_term_ext  = ACCW'(w_term);
  assign w_addend    = r_neg[w_sel] ? -w_term_ext : w_term_ext;
  assign w_acc_next  = r_acc + w_addend;
  assign w_acc_ext   = 64'(w_acc_next);
  assign w_acc_clamp = sat_to_width(w_acc_ext, WIDTH);
  assign w_fsat      = (w_acc_clamp != w_acc_ext);
  assign w_last      = (r_idx == r_n - NW'(1));

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid) w_next = (w_n_clamp == '0) ? DONE : RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_shamt    <= '0;
      r_dir      <= '0;
      r_neg      <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_x     <= bus.in_data;
          r_shamt <= bus.in_shamt;
          r_dir   <= bus.in_dir;
          r_neg   <= bus.in_neg;
          r_n     <= w_n_clamp;
          r_idx   <= '0;
          r_acc   <= '0;
          r_sat   <= 1'b0;
          if (w_n_clamp == '0) begin
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + NW'(1);
          r_sat <= r_sat | w_term_sat;
          if (w_last) begin
            r_out_data <= WIDTH'(w_acc_clamp);
            r_out_sat  <= r_sat | w_term_sat | w_fsat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_accumulator.sv
// ============================================================================
// tb_shift_accumulator : directed checks on floor (ia) and round (ib) instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_shift_accumulator;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   lat;

  shift_accumulator_if #(.WIDTH(21), .SHAMT_W(4), .MAX_TERMS(4)) ia ();
  shift_accumulator_if #(.WIDTH(21), .SHAMT_W(4), .MAX_TERMS(4)) ib ();

  shift_accumulator #(.WIDTH(21), .SHAMT_W(4), .MAX_TERMS(4), .ROUND(0)) dut_floor (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  shift_accumulator #(.WIDTH(21), .SHAMT_W(4), .MAX_TERMS(4), .ROUND(1)) dut_round (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic signed [20:0] x, input int n, input logic [15:0] sh,
                       input logic [3:0] dir, input logic [3:0] neg);
    ia.in_data = x;    ib.in_data = x;
    ia.in_nterms = 3'(n); ib.in_nterms = 3'(n);
    ia.in_shamt = sh;  ib.in_shamt = sh;
    ia.in_dir = dir;   ib.in_dir = dir;
    ia.in_neg = neg;   ib.in_neg = neg;
    ia.in_valid = 1'b1; ib.in_valid = 1'b1;
  endtask

  // Accept on the next edge, then count edges until the result is valid.
  task automatic issue(input logic signed [20:0] x, input int n, input logic [15:0] sh,
                       input logic [3:0] dir, input logic [3:0] neg);
    drive(x, n, sh, dir, neg);
    @(posedge clk); #1;
    ia.in_valid = 1'b0; ib.in_valid = 1'b0;
    lat = 0;
    while (!ia.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_timeout", longint'(ia.out_valid), 1);
  endtask

  task automatic release_out();
    ia.out_ready = 1'b1; ib.out_ready = 1'b1;
    @(posedge clk); #1;
    ia.out_ready = 1'b0; ib.out_ready = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.in_data = '0; ia.in_nterms = '0; ia.in_shamt = '0;
    ia.in_dir = '0; ia.in_neg = '0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.in_nterms = '0; ib.in_shamt = '0;
    ib.in_dir = '0; ib.in_neg = '0; ib.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  longint'(ia.in_ready), 1);
    chk("rst_out_valid", longint'(ia.out_valid), 0);
    chk("rst_out_data",  longint'(ia.out_data), 0);
    chk("rst_out_sat",   longint'(ia.out_sat), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // x=-1001 right 3: floor -126, half-up -125
    issue(-21'sd1001, 1, 16'h0003, 4'b0001, 4'b0000);
    chk("floor_r3", longint'(ia.out_data), -126);
    chk("floor_r3_sat", longint'(ia.out_sat), 0);
    chk("round_r3", longint'(ib.out_data), -125);
    chk("lat_n1", lat, 1);
    release_out();

    issue(-21'sd1000, 1, 16'h0003, 4'b0001, 4'b0000);
    chk("floor_m1000", longint'(ia.out_data), -125);
    chk("round_m1000", longint'(ib.out_data), -125);
    release_out();

    // Right shift by 15 of -5: floor -1, half-up adds sign bit -> 0
    issue(-21'sd5, 1, 16'h000F, 4'b0001, 4'b0000);
    chk("floor_r15", longint'(ia.out_data), -1);
    chk("round_r15", longint'(ib.out_data), 0);
    release_out();

    issue(21'sd300000, 1, 16'h0004, 4'b0000, 4'b0000);
    chk("shl_pos_sat", longint'(ia.out_data), 1048575);
    chk("shl_pos_sat_flag", longint'(ia.out_sat), 1);
    release_out();

    issue(-21'sd300000, 1, 16'h0004, 4'b0000, 4'b0000);
    chk("shl_neg_sat", longint'(ia.out_data), -1048576);
    chk("shl_neg_sat_flag", longint'(ia.out_sat), 1);
    release_out();

    issue(21'sd0, 1, 16'h000F, 4'b0000, 4'b0000);
    chk("shl_zero", longint'(ia.out_data), 0);
    chk("shl_zero_sat", longint'(ia.out_sat), 0);
    release_out();

    // 1024: +(>>3) -(>>6) +(<<1) = 128 - 16 + 2048
    issue(21'sd1024, 3, 16'h0163, 4'b0011, 4'b0010);
    chk("multi_sum", longint'(ia.out_data), 2160);
    chk("multi_sat", longint'(ia.out_sat), 0);
    chk("multi_lat", lat, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("multi_hold", longint'(ia.out_data), 2160);
    end
    release_out();
    chk("multi_ret_ready", longint'(ia.in_ready), 1);

    issue(21'sd5, 0, 16'h0000, 4'b0000, 4'b0000);
    chk("empty_data", longint'(ia.out_data), 0);
    chk("empty_lat", lat, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        ia.in_valid = 1'b1; ia.in_data = 21'sd777; ia.in_nterms = 3'd1;
        ib.in_valid = 1'b1; ib.in_data = 21'sd777; ib.in_nterms = 3'd1;
      end
      @(posedge clk); #1;
      ia.in_valid = 1'b0; ib.in_valid = 1'b0;
      chk("bp_in_ready", longint'(ia.in_ready), 0);
      chk("bp_out_valid", longint'(ia.out_valid), 1);
      chk("bp_out_data", longint'(ia.out_data), 0);
    end
    release_out();
    chk("bp_ret_ready", longint'(ia.in_ready), 1);
    chk("bp_ret_valid", longint'(ia.out_valid), 0);
    @(posedge clk); #1;
    chk("bp_pulse_ignored", longint'(ia.out_valid), 0);

    // Term count 7 clamps to 4: four copies of x=1
    issue(21'sd1, 7, 16'h0000, 4'b0000, 4'b0000);
    chk("clamp_sum", longint'(ia.out_data), 4);
    chk("clamp_lat", lat, 4);
    release_out();

    // Negating the most negative operand is exact, then final sum saturates
    issue(-21'sd1048576, 1, 16'h0000, 4'b0000, 4'b0001);
    chk("neg_min", longint'(ia.out_data), 1048575);
    chk("neg_min_sat", longint'(ia.out_sat), 1);
    release_out();

    // Reset after two of four terms
    drive(21'sd100, 4, 16'h0000, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    ia.in_valid = 1'b0; ib.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_in_ready", longint'(ia.in_ready), 1);
    chk("midrun_out_valid", longint'(ia.out_valid), 0);
    chk("midrun_out_data", longint'(ia.out_data), 0);
    issue(21'sd100, 4, 16'h0000, 4'b0000, 4'b0000);
    chk("post_rst_sum", longint'(ia.out_data), 400);
    chk("post_rst_lat", lat, 4);
    release_out();

    issue(21'sd1048575, 4, 16'h0000, 4'b0000, 4'b0000);
    chk("final_sat", longint'(ia.out_data), 1048575);
    chk("final_sat_flag", longint'(ia.out_sat), 1);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
